instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch stage feeding the controller/datapath. Owns the PC register
//  and fetches each instruction from instruction memory over a req/valid handshake. Holds it stable
//  for decode until the core signals retire. Consumes the controller's o_pc_src to select the next PC.
//  Flags a misaligned control-transfer target and halts on it.
// PARAMETERS
//  XLEN      32            datapath/PC width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//  i_clk          in   1     single clock, all state updates on rising edge
//  i_rst          in   1     asynchronous, active-high reset
//  i_pc_src       in   2     next-PC select from controller: 00 pc+4, 01 branch/jal, 10 jalr, 11 reserved
//  i_pc_target    in   XLEN  pc+imm target (branch/jal)
//  i_alu_result   in   XLEN  rs1+imm target (jalr)
//  i_retire       in   1     current instruction has completed; commit next PC
//  o_imem_req     out  1     fetch request, held high until accepted
//  o_imem_addr    out  XLEN  fetch address (= o_pc while o_imem_req)
//  i_imem_valid   in   1     rdata valid; completes the request in the same cycle
//  i_imem_rdata   in   32    fetched instruction word
//  o_instr        out  32    instruction presented to decode
//  o_instr_valid  out  1     o_instr is valid and stable
//  o_pc           out  XLEN  PC of o_instr
//  o_pc_plus4     out  XLEN  o_pc + 4 (link value for jal/jalr)
//  o_misaligned   out  1     sticky: committed target had addr[1:0] != 0; core halted
// BEHAVIOUR
//  FSM states: FETCH, EXEC, HALT. Reset state: FETCH.
//  Reset values: pc=RESET_PC, o_instr=32'h0000_0013 (NOP), o_instr_valid=0, o_misaligned=0.
//   o_imem_req=1 is a decode of FETCH, so it is high immediately after reset release.
//  FETCH:
//   - o_imem_req=1, o_imem_addr=pc.
//   - On the edge where i_imem_valid=1: o_instr<=i_imem_rdata, o_instr_valid<=1, go to EXEC.
//   - A zero-wait memory (valid in the same cycle) gives a 1-cycle FETCH; no upper bound on wait.
//  EXEC:
//   - o_imem_req=0; o_instr/o_pc held stable until i_retire.
//   - On i_retire: compute next_pc, o_instr_valid<=0.
//   - If next_pc[1:0]==0: pc<=next_pc, go to FETCH.
//   - Else: pc unchanged, o_misaligned<=1, go to HALT.
//  HALT: terminal. o_imem_req=0, o_instr_valid=0. Exited only by i_rst.
//  next_pc rules:
//   - 00 and 11: pc+4.
//   - 01: i_pc_target.
//   - 10: {i_alu_result[XLEN-1:1],1'b0} (bit0 cleared per RV32I); only bit1 can then misalign.
//  Arithmetic: all additions are mod 2^XLEN; pc=32'hFFFF_FFFC + 4 wraps to 0 with no flag.
//  Ignored inputs:
//   - i_imem_valid outside FETCH is ignored.
//   - i_retire outside EXEC is ignored.
//   - i_pc_src, i_pc_target and i_alu_result are sampled only on the retiring edge.
//  Reset asserted mid-fetch or mid-exec: all state returns to reset values asynchronously.
//   - The outstanding request is abandoned; memory must tolerate a dropped req.
//  o_pc_plus4 is combinational from pc; o_pc=pc.
// STRUCTURE
//  riscv_pkg:
//   - pc_src encodings PC_SRC_PLUS4=2'b00, PC_SRC_BRANCH=2'b01, PC_SRC_JALR=2'b10.
//   - Fetch FSM state enum (FETCH/EXEC/HALT).
//   - NOP_INSTR=32'h0000_0013.
//   - RESET_PC default.
//  Sub-module next_pc_gen (combinational):
//   - inputs pc, pc_src, target, alu_result; outputs next_pc and misaligned.
//   - pc register, FSM and instruction latch stay in instr_fetch_unit.
// TESTING
//  1 Reset, then zero-wait memory returning 32'h00500093 at addr 0
//     -> req high at cycle 0, o_instr_valid=1 after 1 edge, o_pc=0, o_pc_plus4=4.
//  2 Memory with 3 wait cycles
//     -> req and addr held steady 3 cycles, o_instr latched only on the valid edge.
//     -> i_retire pulses during FETCH have no effect.
//  3 Retire with pc_src=01, target=32'h0000_0040, from pc=8
//     -> next fetch addr 0x40.
//     -> pc_src=00 gives 0xC; pc_src=11 also gives 0xC.
//  4 Retire with pc_src=10, alu_result=32'h0000_0105
//     -> fetch addr 0x104, no flag.
//     -> alu_result=32'h0000_0106 -> o_misaligned=1, HALT, req stays 0, pc unchanged.
//  5 Assert i_rst mid-wait in FETCH (pc=0x40) and in HALT
//     -> immediate pc=RESET_PC, o_instr_valid=0, o_misaligned=0.
//     -> FETCH of addr 0 restarts after release.
//  6 pc=32'hFFFF_FFFC, retire with pc_src=00 -> pc wraps to 0, next fetch addr 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_pkg;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection and alignment check for control transfers.
module next_pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] target,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc = pc + XLEN'(4);
    case (pc_src)
      PC_SRC_BRANCH: next_pc = target;
      // jalr drops bit 0 of the computed address, so only bit 1 can misalign
      PC_SRC_JALR:   next_pc = alu_result & ~XLEN'(1);
      default:       next_pc = pc + XLEN'(4);
    endcase
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and fetch FSM: fetches one instruction, holds it for decode until retire, halts on misalignment.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_pc_src,
  input  logic [XLEN-1:0]     i_pc_target,
  input  logic [XLEN-1:0]     i_alu_result,
  input  logic                i_retire,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         o_instr,
  output logic                o_instr_valid,
  output logic [XLEN-1:0]     o_pc,
  output logic [XLEN-1:0]     o_pc_plus4,
  output logic                o_misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] next_pc;
  logic            next_pc_misaligned;

  next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
    .pc         (pc_q),
    .pc_src     (i_pc_src),
    .target     (i_pc_target),
    .alu_result (i_alu_result),
    .next_pc    (next_pc),
    .misaligned (next_pc_misaligned)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = misaligned_q;
    case (state_q)
      FETCH: begin
        if (imem.imem_valid) begin
          instr_d       = imem.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (i_retire) begin
          instr_valid_d = 1'b0;
          // A misaligned target is never committed; pc keeps the faulting instruction's address
          if (!next_pc_misaligned) begin
            pc_d    = next_pc;
            state_d = FETCH;
          end else begin
            misaligned_d = 1'b1;
            state_d      = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state_q == FETCH);
    imem.imem_addr = pc_q;
  end

  assign o_instr       = instr_q;
  assign o_instr_valid = instr_valid_q;
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + XLEN'(4);
  assign o_misaligned  = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch waits, next-PC selection, misalignment, async reset, wrap.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_pc_src = 2'b00;
  logic [31:0] i_pc_target = '0;
  logic [31:0] i_alu_result = '0;
  logic        i_retire = 1'b0;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_misaligned;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  instr_fetch_unit_if #(.XLEN(32)) imem_if ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pc_src      (i_pc_src),
    .i_pc_target   (i_pc_target),
    .i_alu_result  (i_alu_result),
    .i_retire      (i_retire),
    .imem          (imem_if),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_misaligned  (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] rdata);
    imem_if.imem_valid = 1'b1;
    imem_if.imem_rdata = rdata;
    tick();
    imem_if.imem_valid = 1'b0;
  endtask

  task automatic do_retire(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    i_pc_src = src; i_pc_target = tgt; i_alu_result = alu; i_retire = 1'b1;
    tick();
    i_retire = 1'b0; i_pc_src = 2'b00; i_pc_target = 32'hDEAD_BEEF; i_alu_result = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    imem_if.imem_valid = 1'b0;
    imem_if.imem_rdata = '0;
    i_rst = 1'b1;
    #7;
    vectors++; if (o_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", o_pc, 32'h0); end
    vectors++; if (o_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", o_instr, 32'h0000_0013); end
    vectors++; if (o_instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_instr_valid); end
    vectors++; if (o_misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_mis: got %b expected 0", o_misaligned); end
    tick();
    i_rst = 1'b0;
    #2;
    vectors++; if (imem_if.imem_req !== 1'b1) begin miscompares++; $display("FAIL reset_req: got %b expected 1", imem_if.imem_req); end
    vectors++; if (imem_if.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", imem_if.imem_addr, 32'h0); end
  endtask

  task automatic test_zero_wait();
    do_fetch(32'h0050_0093);
    vectors++; if (o_instr_valid !== 1'b1) begin miscompares++; $display("FAIL zw_valid: got %b expected 1", o_instr_valid); end
    vectors++; if (o_instr !== 32'h0050_0093) begin miscompares++; $display("FAIL zw_instr: got %h expected %h", o_instr, 32'h0050_0093); end
    vectors++; if (o_pc !== 32'h0) begin miscompares++; $display("FAIL zw_pc: got %h expected %h", o_pc, 32'h0); end
    vectors++; if (o_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL zw_plus4: got %h expected %h", o_pc_plus4, 32'h4); end
    vectors++; if (imem_if.imem_req !== 1'b0) begin miscompares++; $display("FAIL zw_req_exec: got %b expected 0", imem_if.imem_req); end
    // valid while in EXEC must not overwrite the held instruction
    imem_if.imem_valid = 1'b1; imem_if.imem_rdata = 32'h1111_1111;
    tick();
    imem_if.imem_valid = 1'b0;
    vectors++; if (o_instr !== 32'h0050_0093) begin miscompares++; $display("FAIL zw_hold: got %h expected %h", o_instr, 32'h0050_0093); end
    do_retire(2'b00, 32'h0000_0100, 32'h0000_0200);
    vectors++; if (imem_if.imem_addr !== 32'h4) begin miscompares++; $display("FAIL zw_next_addr: got %h expected %h", imem_if.imem_addr, 32'h4); end
    vectors++; if (o_instr_valid !== 1'b0) begin miscompares++; $display("FAIL zw_valid_clr: got %b expected 0", o_instr_valid); end
  endtask

  task automatic test_wait_states();
    i_retire = 1'b1;
    i_pc_src = 2'b01; i_pc_target = 32'h0000_0080;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h4) begin miscompares++; $display("FAIL ws_hold%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_if.imem_req, imem_if.imem_addr, 32'h4); end
      vectors++; if (o_instr_valid !== 1'b0) begin miscompares++; $display("FAIL ws_valid%0d: got %b expected 0", i, o_instr_valid); end
    end
    i_retire = 1'b0; i_pc_src = 2'b00;
    do_fetch(32'h0020_8113);
    vectors++; if (o_instr !== 32'h0020_8113 || o_instr_valid !== 1'b1) begin miscompares++; $display("FAIL ws_latch: got %h/%b expected %h/1", o_instr, o_instr_valid, 32'h0020_8113); end
    vectors++; if (o_pc !== 32'h4) begin miscompares++; $display("FAIL ws_pc: got %h expected %h", o_pc, 32'h4); end
    do_retire(2'b00, 32'h0, 32'h0);
    vectors++; if (imem_if.imem_addr !== 32'h8) begin miscompares++; $display("FAIL ws_next: got %h expected %h", imem_if.imem_addr, 32'h8); end
  endtask

  task automatic test_pc_src();
    do_fetch(32'h0000_0063);
    do_retire(2'b01, 32'h0000_0040, 32'h0000_0500);
    vectors++; if (imem_if.imem_addr !== 32'h40) begin miscompares++; $display("FAIL br_addr: got %h expected %h", imem_if.imem_addr, 32'h40); end
    do_fetch(32'h0000_0063);
    do_retire(2'b01, 32'h0000_0008, 32'h0);
    do_fetch(32'h0000_0013);
    do_retire(2'b00, 32'h0000_0040, 32'h0000_0300);
    vectors++; if (imem_if.imem_addr !== 32'hC) begin miscompares++; $display("FAIL plus4_addr: got %h expected %h", imem_if.imem_addr, 32'hC); end
    do_fetch(32'h0000_0063);
    do_retire(2'b01, 32'h0000_0008, 32'h0);
    do_fetch(32'h0000_0013);
    do_retire(2'b11, 32'h0000_0040, 32'h0000_0300);
    vectors++; if (imem_if.imem_addr !== 32'hC) begin miscompares++; $display("FAIL rsvd_addr: got %h expected %h", imem_if.imem_addr, 32'hC); end
  endtask

  task automatic test_jalr_misalign();
    do_fetch(32'h0000_0067);
    do_retire(2'b10, 32'h0000_0040, 32'h0000_0105);
    vectors++; if (imem_if.imem_addr !== 32'h104) begin miscompares++; $display("FAIL jalr_addr: got %h expected %h", imem_if.imem_addr, 32'h104); end
    vectors++; if (o_misaligned !== 1'b0) begin miscompares++; $display("FAIL jalr_noflag: got %b expected 0", o_misaligned); end
    do_fetch(32'h0000_0067);
    do_retire(2'b10, 32'h0000_0040, 32'h0000_0106);
    vectors++; if (o_misaligned !== 1'b1) begin miscompares++; $display("FAIL mis_flag: got %b expected 1", o_misaligned); end
    vectors++; if (o_pc !== 32'h104) begin miscompares++; $display("FAIL mis_pc: got %h expected %h", o_pc, 32'h104); end
    vectors++; if (imem_if.imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin miscompares++; $display("FAIL mis_halt: got req=%b valid=%b expected 0/0", imem_if.imem_req, o_instr_valid); end
    imem_if.imem_valid = 1'b1; i_retire = 1'b1;
    tick(); tick();
    imem_if.imem_valid = 1'b0; i_retire = 1'b0;
    vectors++; if (imem_if.imem_req !== 1'b0 || o_instr_valid !== 1'b0 || o_misaligned !== 1'b1 || o_pc !== 32'h104) begin miscompares++; $display("FAIL halt_sticky: got req=%b valid=%b mis=%b pc=%h expected 0/0/1/%h", imem_if.imem_req, o_instr_valid, o_misaligned, o_pc, 32'h104); end
  endtask

  task automatic test_async_reset();
    #2 i_rst = 1'b1;
    #1;
    vectors++; if (o_pc !== 32'h0 || o_misaligned !== 1'b0 || o_instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_halt: got pc=%h mis=%b valid=%b expected 0/0/0", o_pc, o_misaligned, o_instr_valid); end
    tick();
    i_rst = 1'b0;
    #1;
    vectors++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_halt_req: got req=%b addr=%h expected 1/0", imem_if.imem_req, imem_if.imem_addr); end
    do_fetch(32'h0000_0063);
    do_retire(2'b01, 32'h0000_0040, 32'h0);
    tick();
    #2 i_rst = 1'b1;
    #1;
    vectors++; if (o_pc !== 32'h0 || o_instr_valid !== 1'b0 || o_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL rst_fetch: got pc=%h valid=%b instr=%h expected 0/0/%h", o_pc, o_instr_valid, o_instr, 32'h0000_0013); end
    tick();
    i_rst = 1'b0;
    #1;
    vectors++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_restart: got req=%b addr=%h expected 1/0", imem_if.imem_req, imem_if.imem_addr); end
    do_fetch(32'h0050_0093);
    vectors++; if (o_instr !== 32'h0050_0093 || o_pc !== 32'h0) begin miscompares++; $display("FAIL rst_refetch: got instr=%h pc=%h expected %h/0", o_instr, o_pc, 32'h0050_0093); end
  endtask

  task automatic test_wrap();
    do_retire(2'b01, 32'hFFFF_FFFC, 32'h0);
    do_fetch(32'h0000_0013);
    vectors++; if (o_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4: got %h expected %h", o_pc_plus4, 32'h0); end
    do_retire(2'b00, 32'h0000_0040, 32'h0);
    vectors++; if (imem_if.imem_addr !== 32'h0 || o_misaligned !== 1'b0 || imem_if.imem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_addr: got addr=%h mis=%b req=%b expected 0/0/1", imem_if.imem_addr, o_misaligned, imem_if.imem_req); end
    do_fetch(32'h0000_0063);
    do_retire(2'b01, 32'h0000_0041, 32'h0);
    vectors++; if (o_misaligned !== 1'b1 || o_pc !== 32'h0 || imem_if.imem_req !== 1'b0) begin miscompares++; $display("FAIL br_mis: got mis=%b pc=%h req=%b expected 1/0/0", o_misaligned, o_pc, imem_if.imem_req); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_pc_src();
    test_jalr_misalign();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
